banked_frame_mem: RTL

- Parametrised multi-bank byte memory for the VGA/SIMD frame path. Generalises the single 64K-bank store to NUM_BANKS banks behind one flat address space.
- Decodes each request to a bank and offset. Pipelines the bank select alongside read data, so responses always come from the correct bank.
- Adds a valid/ready request handshake, an in-order response FIFO with backpressure, and out-of-range detection. The block instantiates its RAM arrays internally as inferred synchronous RAM.

---
 rtl/banked_frame_mem_if.sv | 34 +++
 rtl/banked_frame_mem.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_frame_mem_if.sv
// Request/response bus of the banked frame memory.
//   master : requester side - drives req_valid/req_we/req_addr/req_wdata and
//            rsp_ready; observes req_ready, rsp_valid/rsp_data/rsp_err and the
//            out-of-range counter.
//   slave  : memory side - the mirror image of master.
// ADDR_W is derived from the bank geometry so both ends always agree on it.
interface banked_frame_mem_if #(
  parameter int DATA_W    = 8,
  parameter int BANK_AW   = 16,
  parameter int NUM_BANKS = 5
);
  localparam int ADDR_W = BANK_AW + $clog2(NUM_BANKS);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [7:0]        oor_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, oor_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, oor_count
  );
endinterface

// File: rtl/banked_frame_mem.sv
// Banked byte memory for the frame path: NUM_BANKS banks of 2**BANK_AW words
// behind one flat address space, with a valid/ready request port, an
// RD_LAT-deep read pipeline, an in-order first-word-fall-through response
// FIFO and a saturating out-of-range request counter.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (RAM contents are kept)
//   bus : banked_frame_mem_if slave modport (request, response, oor_count)

// Safety checker for the response path: the FIFO is never pushed while full
// and the credit counter never exceeds the FIFO depth.
module banked_frame_mem_chk #(
  parameter int CNT_W     = 3,
  parameter int RSP_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             push_i,
  input logic [CNT_W-1:0] cnt_i,
  input logic [CNT_W-1:0] out_i
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push_i |-> (32'(cnt_i) < RSP_DEPTH));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    32'(out_i) <= RSP_DEPTH);
endmodule

module banked_frame_mem #(
  parameter int DATA_W    = 8,
  parameter int BANK_AW   = 16,
  parameter int NUM_BANKS = 5,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  banked_frame_mem_if.slave bus
);
  localparam int ADDR_W = BANK_AW + $clog2(NUM_BANKS);
  localparam int SEL_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // One extra bit so NUM_BANKS == 2**SEL_W does not wrap to zero.
  localparam logic [SEL_W:0]   NB_C    = (SEL_W + 1)'(NUM_BANKS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_NIL = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [SEL_W-1:0]   bank_s;
  logic [BANK_AW-1:0] off_s;
  logic               oor_s, req_ready_s, acc_s, rd_acc_s, wr_acc_s;
  logic [DATA_W-1:0]  bank_rd_s [NUM_BANKS];
  logic               s1_v_q, s1_err_q;
  logic [SEL_W-1:0]   s1_sel_q;
  logic [DATA_W-1:0]  s1_data_s;
  logic               push_v_s, push_err_s;
  logic [DATA_W-1:0]  push_data_s;
  logic [DATA_W-1:0]  fifo_data_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_err_q;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, out_q, out_d;
  logic               pop_s, rsp_valid_s, rsp_err_s;
  logic [DATA_W-1:0]  rsp_data_s;
  logic [7:0]         oor_q;

  // Address decode: upper bits select the bank, lower bits the word.
  assign off_s = bus.req_addr[BANK_AW-1:0];
  if (NUM_BANKS > 1) begin : g_sel
    assign bank_s = bus.req_addr[ADDR_W-1:BANK_AW];
  end else begin : g_nosel
    assign bank_s = 1'b0;
  end
  assign oor_s = ({1'b0, bank_s} >= NB_C);

  // Credits come from the registered counter only, so a same-cycle pop does
  // not open the request port early.
  assign req_ready_s = !rst && (out_q < DEPTH_C);
  assign acc_s       = bus.req_valid && req_ready_s;
  assign rd_acc_s    = acc_s && !bus.req_we;
  assign wr_acc_s    = acc_s && bus.req_we && !oor_s;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [2**BANK_AW];
    logic [DATA_W-1:0] rd_q;
    logic              hit_s;
    assign hit_s        = (bank_s == SEL_W'(b));
    assign bank_rd_s[b] = rd_q;
    // Inferred synchronous RAM: write port plus registered read port.
    always_ff @(posedge clk) begin
      if (wr_acc_s && hit_s) begin
        mem_q[off_s] <= bus.req_wdata;
      end
      if (rd_acc_s && hit_s) begin
        rd_q <= mem_q[off_s];
      end
    end
  end

  // Stage 1 control travels with the RAM register; the bank select picks
  // which bank's read register is valid one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_err_q <= 1'b0;
      s1_sel_q <= {SEL_W{1'b0}};
    end else begin
      s1_v_q   <= rd_acc_s;
      s1_err_q <= rd_acc_s && oor_s;
      s1_sel_q <= bank_s;
    end
  end

  // Stage 1 read data: bank mux, forced to zero for out-of-range reads.
  always_comb begin
    s1_data_s = {DATA_W{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      s1_data_s = (s1_sel_q == SEL_W'(b)) ? bank_rd_s[b] : s1_data_s;
    end
    s1_data_s = s1_err_q ? {DATA_W{1'b0}} : s1_data_s;
  end

  if (RD_LAT > 1) begin : g_pipe
    logic [RD_LAT-2:0] xv_q, xe_q;
    logic [DATA_W-1:0] xd_q [RD_LAT-1];
    // Valid bits of the extra latency stages.
    always_ff @(posedge clk) begin
      if (rst) begin
        xv_q <= {(RD_LAT-1){1'b0}};
      end else begin
        xv_q[0] <= s1_v_q;
        for (int k = 1; k < RD_LAT - 1; k++) begin
          xv_q[k] <= xv_q[k-1];
        end
      end
    end
    // Data and error flag of the extra latency stages.
    always_ff @(posedge clk) begin
      xd_q[0] <= s1_data_s;
      xe_q[0] <= s1_err_q;
      for (int k = 1; k < RD_LAT - 1; k++) begin
        xd_q[k] <= xd_q[k-1];
        xe_q[k] <= xe_q[k-1];
      end
    end
    assign push_v_s    = xv_q[RD_LAT-2];
    assign push_err_s  = xe_q[RD_LAT-2];
    assign push_data_s = xd_q[RD_LAT-2];
  end else begin : g_nopipe
    assign push_v_s    = s1_v_q;
    assign push_err_s  = s1_err_q;
    assign push_data_s = s1_data_s;
  end

  // Head of the FIFO, with the entry being pushed shown directly when the
  // FIFO is empty so a read appears RD_LAT cycles after its accept.
  always_comb begin
    rsp_valid_s = (cnt_q != CNT_NIL) || push_v_s;
    if (cnt_q != CNT_NIL) begin
      rsp_data_s = fifo_data_q[rptr_q];
      rsp_err_s  = fifo_err_q[rptr_q];
    end else if (push_v_s) begin
      rsp_data_s = push_data_s;
      rsp_err_s  = push_err_s;
    end else begin
      rsp_data_s = {DATA_W{1'b0}};
      rsp_err_s  = 1'b0;
    end
  end
  assign pop_s = rsp_valid_s && bus.rsp_ready;

  // Next FIFO occupancy and next credit count.
  always_comb begin
    case ({push_v_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    case ({rd_acc_s, pop_s})
      2'b10:   out_d = out_q + CNT_ONE;
      2'b01:   out_d = out_q - CNT_ONE;
      default: out_d = out_q;
    endcase
  end

  // FIFO pointers, occupancy and credit counter. A bypassed entry is both
  // written and popped, so both pointers advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      cnt_q  <= CNT_NIL;
      out_q  <= CNT_NIL;
    end else begin
      wptr_q <= push_v_s ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_q <= pop_s ? (rptr_q + PTR_ONE) : rptr_q;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates them.
  always_ff @(posedge clk) begin
    if (push_v_s) begin
      fifo_data_q[wptr_q] <= push_data_s;
      fifo_err_q[wptr_q]  <= push_err_s;
    end
  end

  // Saturating count of accepted out-of-range requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q <= 8'h00;
    end else if (acc_s && oor_s && (oor_q != 8'hFF)) begin
      oor_q <= oor_q + 8'h01;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = rsp_data_s;
  assign bus.rsp_err   = rsp_err_s;
  assign bus.oor_count = oor_q;

  banked_frame_mem_chk #(.CNT_W(CNT_W), .RSP_DEPTH(RSP_DEPTH)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_v_s),
    .cnt_i  (cnt_q),
    .out_i  (out_q)
  );
endmodule
